// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
// ---------------
// Packet-locked round-robin arbiter between two valid/ready streams (A, B)
// feeding one registered output stage. The arbiter also exports its mux
// select so a downstream 2:1 mux (f = s ? b : a) can follow the same grant.
//
// Once a stream is granted, it keeps the grant until the beat carrying its
// last flag is accepted. The FSM then returns to IDLE for one cycle and
// re-arbitrates. On a tie, the stream that did not finish the previous
// packet wins.
//
// Ports
//   clk_100mhz         sole clock, rising edge
//   reset              synchronous, active-high reset
//   a_valid/a_data/a_last/a_ready   stream A (a_ready is an output)
//   b_valid/b_data/b_last/b_ready   stream B (b_ready is an output)
//   f_valid/f_data/f_last           registered output beat
//   f_ready            downstream accepts the beat when f_valid & f_ready
//   s                  mux select, 0 = A, 1 = B (high only in GRANT_B)
module mux_sel_arbiter #(
  parameter int W = 1
) (
  input  logic         clk_100mhz,
  input  logic         reset,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  input  logic         a_last,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  input  logic         b_last,
  output logic         b_ready,
  output logic         f_valid,
  output logic [W-1:0] f_data,
  output logic         f_last,
  input  logic         f_ready,
  output logic         s
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  // rr encoding: 0 = A finished last, 1 = B finished last.
  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

  state_t         state_reg, state_next;
  logic           rr_reg, rr_next;

  logic           f_valid_reg;
  logic [W-1:0]   f_data_reg;
  logic           f_last_reg;

  logic           can_load;
  logic           a_acc;
  logic           b_acc;
  logic [W-1:0]   mux_data;
  logic           mux_last;

  // The output register can take a new beat when it is empty or is being
  // drained this cycle, which gives full throughput with no bubble.
  assign can_load = !f_valid_reg || f_ready;
  assign a_acc    = a_valid && a_ready;
  assign b_acc    = b_valid && b_ready;

  // ---------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state_reg <= IDLE;
      rr_reg    <= RR_B;  // so that A wins the first tie
    end else begin
      state_reg <= state_next;
      rr_reg    <= rr_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    rr_next    = rr_reg;
    case (state_reg)
      IDLE: begin
        if (a_valid && b_valid) begin
          state_next = (rr_reg == RR_A) ? GRANT_B : GRANT_A;
        end else if (a_valid) begin
          state_next = GRANT_A;
        end else if (b_valid) begin
          state_next = GRANT_B;
        end
      end
      GRANT_A: begin
        // Grant is released only by the accepted last beat; a valid that
        // drops mid-packet just leaves us waiting here.
        if (a_acc && a_last) begin
          state_next = IDLE;
          rr_next    = RR_A;
        end
      end
      GRANT_B: begin
        if (b_acc && b_last) begin
          state_next = IDLE;
          rr_next    = RR_B;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM process 3: outputs
  // ---------------------------------------------------------------------
  // Ready is also masked by reset so that no upstream handshake can appear
  // to complete in a cycle whose state is about to be discarded.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    s       = 1'b0;
    case (state_reg)
      GRANT_A: begin
        a_ready = can_load && !reset;
      end
      GRANT_B: begin
        b_ready = can_load && !reset;
        s       = 1'b1;
      end
      default: begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        s       = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Data path: same select as the external mux, bit by bit
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_mux
      assign mux_data[gi] = s ? b_data[gi] : a_data[gi];
    end
  endgenerate

  assign mux_last = s ? b_last : a_last;

  // Output register. A new acceptance always wins over a drain, so a
  // simultaneous f_ready and acceptance replaces the beat in place.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      f_valid_reg <= 1'b0;
      f_data_reg  <= '0;
      f_last_reg  <= 1'b0;
    end else if (a_acc || b_acc) begin
      f_valid_reg <= 1'b1;
      f_data_reg  <= mux_data;
      f_last_reg  <= mux_last;
    end else if (f_ready) begin
      f_valid_reg <= 1'b0;
    end
  end

  assign f_valid = f_valid_reg;
  assign f_data  = f_data_reg;
  assign f_last  = f_last_reg;

endmodule
